// File: rtl/cp_insert.sv
// rtl/cp_insert.sv - transmit-side cyclic-prefix inserter; optional sym_cnt output via CP_INSERT_SYM_CNT_EN
module cp_insert #(
    parameter int N      = 256,
    parameter int CP_LEN = 64,
    parameter int DW     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] in_real,
    input  logic signed [DW-1:0] in_imag,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [DW-1:0] out_real,
    output logic signed [DW-1:0] out_imag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sof,
    output logic                 out_sym_start
`ifdef CP_INSERT_SYM_CNT_EN
    ,
    output logic [15:0]          sym_cnt
`endif
);

    localparam int AW = $clog2(N);
    localparam int CW = $clog2(N + CP_LEN + 1);

    if (CP_LEN < 1 || CP_LEN > N - 1) begin : g_bad_cp_len
        $error("cp_insert: CP_LEN must be in 1..N-1");
    end
    if (N < 8 || N > 4096 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("cp_insert: N must be a power of 2 in 8..4096");
    end

    typedef enum logic [1:0] {FILL, EMIT_CP, EMIT_SYM} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;
    logic [CW-1:0]     ld_left;
    logic [2*DW-1:0]   sym_mem [N];
    logic [2*DW-1:0]   fill_data;
    logic              in_fire;
    logic              out_fire;
    logic              last_in;
    logic              load;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign last_in  = in_fire & (wr_idx == AW'(N - 1));
    assign load     = (state != FILL) & (ld_left != '0) & (~out_valid | out_ready);

    // The first CP sample is loaded on the same edge as the last input; with CP_LEN==1 it is that input.
    assign fill_data = (CP_LEN == 1) ? {in_real, in_imag} : sym_mem[AW'(N - CP_LEN)];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // ld_left counts loads still owed; it equals N while the last CP sample sits in the output register.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL:     if (last_in) state_nxt = EMIT_CP;
            EMIT_CP:  if (out_fire && ld_left == CW'(N)) state_nxt = EMIT_SYM;
            EMIT_SYM: if (out_fire && ld_left == '0) state_nxt = FILL;
            default:  state_nxt = FILL;
        endcase
    end

    always_comb begin
        in_ready = (state == FILL) & ~rst;
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            sym_mem[wr_idx] <= {in_real, in_imag};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx        <= '0;
            rd_idx        <= '0;
            ld_left       <= '0;
            out_valid     <= 1'b0;
            out_real      <= '0;
            out_imag      <= '0;
            out_sof       <= 1'b0;
            out_sym_start <= 1'b0;
        end else begin
            if (in_fire) begin
                wr_idx <= last_in ? '0 : wr_idx + AW'(1);
            end
            if (last_in) begin
                {out_real, out_imag} <= fill_data;
                out_valid            <= 1'b1;
                out_sof              <= 1'b1;
                out_sym_start        <= 1'b0;
                rd_idx               <= AW'(N - CP_LEN + 1);
                ld_left              <= CW'(N + CP_LEN - 1);
            end else if (load) begin
                {out_real, out_imag} <= sym_mem[rd_idx];
                out_valid            <= 1'b1;
                out_sof              <= 1'b0;
                out_sym_start        <= (ld_left == CW'(N));
                rd_idx               <= rd_idx + AW'(1);
                ld_left              <= ld_left - CW'(1);
            end else if (out_fire) begin
                out_valid     <= 1'b0;
                out_sof       <= 1'b0;
                out_sym_start <= 1'b0;
            end
        end
    end

`ifdef CP_INSERT_SYM_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sym_cnt <= '0;
        end else if (state == EMIT_SYM && out_fire && ld_left == '0) begin
            sym_cnt <= sym_cnt + 16'd1;
        end
    end
`endif

endmodule
